// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
  localparam int WDOG_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts wait cycles of the in-flight memory transaction and flags a bus timeout.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  input  logic busy,
  output logic expire,
  output logic err
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT);

  logic [WDOG_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;

  always_comb begin
    expire = busy & ~ack & (cnt_q == LIMIT);
    cnt_d  = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (busy && !ack && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Sticky until reset so software can see that a transaction was abandoned.
    err_d = err_q | expire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serializes IF-stage fetches and MEM-stage loads/stores onto one memory port,
// data first, and stalls the pipeline until every access of the cycle is done.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifData,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic [DATA_W-1:0] dRData,
  output logic              stall,
  output logic              mReq,
  output logic              mWe,
  output logic [ADDR_W-1:0] mAddr,
  output logic [DATA_W-1:0] mWData,
  input  logic [DATA_W-1:0] mRData,
  input  logic              mAck,
  output logic              busErr
);

  arb_state_e        state_q, state_d;
  logic              mreq_q, mreq_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic [DATA_W-1:0] ifdata_q, ifdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              dflag_q, dflag_d;
  logic              fflag_q, fflag_d;

  logic dPend, dNeed, fNeed, advance;
  logic busy, ackV, wdStart, wdExpire;
  logic dSet, fSet;

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .start (wdStart),
    .ack   (ackV),
    .busy  (busy),
    .expire(wdExpire),
    .err   (busErr)
  );

  always_comb begin
    dPend   = memRead | memWrite;
    dNeed   = dPend & ~dflag_q;
    fNeed   = ifReq & ~fflag_q;
    stall   = dNeed | fNeed;
    advance = ~stall;
    busy    = (state_q != IDLE);
    // An acknowledge only counts while a request is actually outstanding.
    ackV    = mAck & mreq_q & busy;
  end

  always_comb begin
    state_d  = state_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    ifdata_d = ifdata_q;
    drdata_d = drdata_q;
    wdStart  = 1'b0;
    dSet     = 1'b0;
    fSet     = 1'b0;

    case (state_q)
      IDLE: begin
        if (dNeed) begin
          state_d  = DATA;
          mreq_d   = 1'b1;
          mwe_d    = memWrite;
          maddr_d  = dAddr;
          mwdata_d = dWData;
          wdStart  = 1'b1;
        end else if (fNeed) begin
          state_d = FETCH;
          mreq_d  = 1'b1;
          mwe_d   = 1'b0;
          maddr_d = ifAddr;
          wdStart = 1'b1;
        end
      end

      DATA: begin
        if (ackV) begin
          // A requester that went away mid-flight gets neither data nor a done flag.
          if (dPend) begin
            dSet = 1'b1;
            if (!mwe_q) drdata_d = mRData;
          end
          if (fNeed) begin
            state_d = FETCH;
            mreq_d  = 1'b1;
            mwe_d   = 1'b0;
            maddr_d = ifAddr;
            wdStart = 1'b1;
          end else begin
            state_d = IDLE;
            mreq_d  = 1'b0;
            mwe_d   = 1'b0;
          end
        end else if (wdExpire) begin
          dSet    = 1'b1;
          state_d = IDLE;
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
        end
      end

      FETCH: begin
        if (ackV) begin
          if (ifReq) begin
            fSet     = 1'b1;
            ifdata_d = mRData;
          end
          state_d = IDLE;
          mreq_d  = 1'b0;
        end else if (wdExpire) begin
          fSet    = 1'b1;
          state_d = IDLE;
          mreq_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        mreq_d  = 1'b0;
        mwe_d   = 1'b0;
      end
    endcase

    // Flags live for exactly one pipeline step: cleared on the edge the pipeline moves.
    dflag_d = advance ? 1'b0 : (dflag_q | dSet);
    fflag_d = advance ? 1'b0 : (fflag_q | fSet);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      ifdata_q <= '0;
      drdata_q <= '0;
      dflag_q  <= 1'b0;
      fflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      ifdata_q <= ifdata_d;
      drdata_q <= drdata_d;
      dflag_q  <= dflag_d;
      fflag_q  <= fflag_d;
    end
  end

  assign mReq   = mreq_q;
  assign mWe    = mwe_q;
  assign mAddr  = maddr_q;
  assign mWData = mwdata_q;
  assign ifData = ifdata_q;
  assign dRData = drdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: expected memory requests and latched results are queued as
// stimulus is driven and compared when the arbiter issues/releases them.
module tb_unified_mem_arbiter;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq, memRead, memWrite, mAck, stall, mReq, mWe, busErr;
  logic [31:0] ifAddr, ifData, dAddr, dWData, dRData, mAddr, mWData, mRData;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] ifd;
    logic [31:0] drd;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];
  req_t cur = '0;

  int n_chk  = 0;
  int n_pass = 0;

  int          wait_cfg   = 0;
  bit          resp_en    = 1'b0;
  bit          force_ack  = 1'b0;
  logic [31:0] stray_data = 32'h0;
  bit          prev_req   = 1'b0;
  bit          prev_ack   = 1'b0;
  int          wcnt       = 0;

  logic [31:0] ifd_m = 32'h0;
  logic [31:0] drd_m = 32'h0;
  logic        err_m = 1'b0;

  unified_mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ifReq   (ifReq),
    .ifAddr  (ifAddr),
    .ifData  (ifData),
    .memRead (memRead),
    .memWrite(memWrite),
    .dAddr   (dAddr),
    .dWData  (dWData),
    .dRData  (dRData),
    .stall   (stall),
    .mReq    (mReq),
    .mWe     (mWe),
    .mAddr   (mAddr),
    .mWData  (mWData),
    .mRData  (mRData),
    .mAck    (mAck),
    .busErr  (busErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h2002000A;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: checks each request against the scoreboard every cycle it is held,
  // then acknowledges after wait_cfg wait-states.
  initial begin
    mAck   = 1'b0;
    mRData = 32'h0;
    forever begin
      @(negedge clk);
      if (mReq && (!prev_req || prev_ack)) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 32'd1, 32'd0);
          cur = '0;
        end else begin
          cur = req_q.pop_front();
        end
        wcnt = 0;
      end
      if (mReq) begin
        chk("mAddr", mAddr, cur.addr);
        chk("mWe", {31'b0, mWe}, {31'b0, cur.we});
        if (cur.we) chk("mWData", mWData, cur.wdata);
      end
      prev_req = mReq;
      mAck     = force_ack;
      if (force_ack) mRData = stray_data;
      if (mReq && resp_en) begin
        if (wcnt == wait_cfg) begin
          mAck   = 1'b1;
          mRData = mem_word(mAddr);
          wcnt   = 0;
        end else begin
          wcnt++;
        end
      end
      prev_ack = mAck;
    end
  end

  task automatic run_op(input logic rd, input logic wr, input logic fr,
                        input logic [31:0] da, input logic [31:0] wd, input logic [31:0] fa,
                        input int waits, input bit ack_on, input int exp_cyc, input string tag);
    int   n;
    bit   rel;
    res_t r;
    wait_cfg = waits;
    resp_en  = ack_on;
    if (rd || wr) req_q.push_back('{wr, da, wd});
    if (fr) req_q.push_back('{1'b0, fa, 32'h0});
    if (rd && ack_on) drd_m = mem_word(da);
    if (fr && ack_on) ifd_m = mem_word(fa);
    if (!ack_on) err_m = 1'b1;
    res_q.push_back('{ifd_m, drd_m});
    @(posedge clk); #1;
    memRead = rd; memWrite = wr; ifReq = fr;
    dAddr = da; dWData = wd; ifAddr = fa;
    n   = 0;
    rel = 1'b0;
    while (!rel && n < 600) begin
      @(negedge clk);
      if (!stall) rel = 1'b1;
      else n++;
    end
    chk({tag, "_released"}, {31'b0, rel}, 32'd1);
    chk({tag, "_stall_cycles"}, n, exp_cyc);
    r = res_q.pop_front();
    chk({tag, "_ifData"}, ifData, r.ifd);
    chk({tag, "_dRData"}, dRData, r.drd);
    chk({tag, "_busErr"}, {31'b0, busErr}, {31'b0, err_m});
    chk({tag, "_mReq_idle"}, {31'b0, mReq}, 32'd0);
    memRead = 1'b0; memWrite = 1'b0; ifReq = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_stall_after"}, {31'b0, stall}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    ifReq = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    ifAddr = 32'h0; dAddr = 32'h0; dWData = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mReq", {31'b0, mReq}, 32'd0);
    chk("rst_mWe", {31'b0, mWe}, 32'd0);
    chk("rst_mAddr", mAddr, 32'd0);
    chk("rst_mWData", mWData, 32'd0);
    chk("rst_ifData", ifData, 32'd0);
    chk("rst_dRData", dRData, 32'd0);
    chk("rst_busErr", {31'b0, busErr}, 32'd0);
    chk("rst_stall_idle", {31'b0, stall}, 32'd0);
    ifReq = 1'b1; #1;
    chk("rst_stall_follows", {31'b0, stall}, 32'd1);
    ifReq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(0, 0, 1, 32'h0,   32'h0,        32'h40, 0, 1'b1, 2,      "fetch0w");
    run_op(1, 0, 1, 32'h104, 32'h0,        32'h50, 0, 1'b1, 3,      "ldfetch0w");
    run_op(1, 0, 1, 32'h100, 32'h0,        32'h44, 2, 1'b1, 7,      "ldfetch2w");
    run_op(0, 1, 0, 32'h8,   32'hDEADBEEF, 32'h0,  3, 1'b1, 5,      "store3w");
    run_op(0, 1, 1, 32'hC,   32'h0BADF00D, 32'h60, 1, 1'b1, 5,      "stfetch1w");
    run_op(0, 0, 1, 32'h0,   32'h0,        32'h70, 1, 1'b1, 3,      "fetch1w");
    run_op(0, 0, 1, 32'h0,   32'h0,        32'h80, 0, 1'b0, TO + 2, "timeout");
    run_op(1, 0, 0, 32'h204, 32'h0,        32'h0,  1, 1'b1, 3,      "after_to");

    // Fetch abandoned by the IF stage before its acknowledge.
    wait_cfg = 2;
    resp_en  = 1'b1;
    req_q.push_back('{1'b0, 32'h48, 32'h0});
    @(posedge clk); #1;
    ifReq = 1'b1; ifAddr = 32'h48;
    @(negedge clk);
    chk("drop_stall_c0", {31'b0, stall}, 32'd1);
    @(negedge clk);
    chk("drop_mReq_c1", {31'b0, mReq}, 32'd1);
    ifReq = 1'b0;
    n = 0;
    while (mReq && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drop_completes", n, 32'd3);
    chk("drop_ifData", ifData, ifd_m);
    chk("drop_stall_low", {31'b0, stall}, 32'd0);
    ifReq = 1'b1; #1;
    chk("drop_fflag_clear", {31'b0, stall}, 32'd1);
    ifReq = 1'b0;

    // Reset in the middle of a data transaction, followed by a stray acknowledge.
    wait_cfg = 0;
    resp_en  = 1'b0;
    req_q.push_back('{1'b0, 32'h200, 32'h0});
    @(posedge clk); #1;
    memRead = 1'b1; dAddr = 32'h200;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_mReq_before", {31'b0, mReq}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_mReq", {31'b0, mReq}, 32'd0);
    chk("rstmid_mWe", {31'b0, mWe}, 32'd0);
    chk("rstmid_mAddr", mAddr, 32'd0);
    chk("rstmid_ifData", ifData, 32'd0);
    chk("rstmid_dRData", dRData, 32'd0);
    chk("rstmid_busErr", {31'b0, busErr}, 32'd0);
    memRead = 1'b0;
    ifd_m = 32'h0; drd_m = 32'h0; err_m = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    stray_data = 32'h12345678;
    force_ack  = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    chk("stray_mReq", {31'b0, mReq}, 32'd0);
    chk("stray_dRData", dRData, drd_m);
    chk("stray_ifData", ifData, ifd_m);
    chk("stray_stall", {31'b0, stall}, 32'd0);

    run_op(1, 0, 1, 32'h300, 32'h0, 32'h90, 1, 1'b1, 5, "post_rst");
    chk("req_queue_drained", req_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported, variable-latency memory between the IF-stage instruction fetch and the MEM-stage load/store of the pipelined MIPS core. A three-state FSM serializes the two requesters, with data taking priority. Completed results are latched and held. A single pipeline-wide stall is produced until every pending access of the current cycle has completed. The block sits beside the CPU controller; its stall is ORed into the existing hazard stall (PC write / IF-ID load disable, ID-EX hold).

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles a transaction may wait for mAck before busErr; 8-bit counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- ifReq  in  1  fetch requested this cycle
- ifAddr  in  ADDR_W  fetch address (PC)
- ifData  out  DATA_W  latched instruction
- memRead, memWrite  in  1 each  MEM-stage load/store; never both high
- dAddr  in  ADDR_W  load/store address
- dWData  in  DATA_W  store data
- dRData  out  DATA_W  latched load data
- stall  out  1  freeze pipeline; combinational
- mReq  out  1  memory request; registered
- mWe  out  1  write enable; registered
- mAddr  out  ADDR_W  memory address; registered
- mWData  out  DATA_W  memory write data; registered
- mRData  in  DATA_W  read data; valid only with mAck
- mAck  in  1  one-cycle completion pulse for the current request
- busErr  out  1  sticky timeout flag; cleared only by rst

## Operation
- State encoding: IDLE=0, DATA=1, FETCH=2. Internal flags: dFlag and fFlag, the "done" flags.
- Pending data access: dPend = memRead|memWrite.
- stall = (dPend & ~dFlag) | (ifReq & ~fFlag).
- advance = ~stall. On a rising edge with advance high, both flags clear.
- IDLE transitions:
  - If dPend & ~dFlag, go to DATA. Load mAddr=dAddr, mWe=memWrite, mWData=dWData, mReq=1.
  - Else if ifReq & ~fFlag, go to FETCH. Load mAddr=ifAddr, mWe=0, mReq=1.
  - Data always wins; fetch waits at most one transaction.
- DATA or FETCH:
  - Memory outputs are held stable until mAck.
  - On mAck in DATA: latch dRData=mRData on a read, leave dRData unchanged on a write, and set dFlag.
  - On mAck in FETCH: latch ifData=mRData and set fFlag.
  - Next state after mAck: DATA goes to FETCH if ifReq & ~fFlag, reloading the memory outputs that edge with mReq still high; otherwise IDLE with mReq=0. FETCH always goes to IDLE.
- Requester drops mid-flight (ifReq or dPend low at mAck): the transaction still completes, the result is discarded and the flag is not set.
- Watchdog:
  - Counter resets on each new request and counts cycles in DATA/FETCH without mAck.
  - On reaching TIMEOUT, set busErr, force the flag for the in-flight side to release the pipeline (data unchanged), and return to IDLE with mReq=0.
- Reset: state=IDLE, mReq=0, mWe=0, mAddr=0, mWData=0, ifData=0, dRData=0, flags=0, counter=0, busErr=0.
  - stall after reset follows the inputs.
  - Reset mid-transaction drops mReq immediately; a later stray mAck in IDLE is ignored.

## Timing
- Fetch only, zero-wait memory (mAck in the first mReq cycle):
  - cycle 0: stall high.
  - cycle 1: mReq high, mAck.
  - cycle 2: fFlag set, stall low, pipeline advances at the end of cycle 2.
  - Fetch cost: 3 cycles.
- Load plus fetch, zero-wait: DATA in cycle 1, FETCH in cycle 2 (back-to-back mReq), stall low in cycle 3.
- Each memory wait-state adds one cycle.
- mAck while mReq is low is ignored.
- busErr rises the edge after the counter reaches TIMEOUT.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE/DATA/FETCH)
  - ADDR_W, DATA_W defaults
  - TIMEOUT default
- Natural sub-module: mem_arb_watchdog. Inputs: clk, rst, start, ack, busy. Outputs: expire pulse, sticky err.
- FSM, flags and latches stay in the top.

## Test plan
- Fetch-only, zero-wait, ifAddr=0x40, mRData=0x2002000A → mReq in cycle 1 with mAddr=0x40 and mWe=0; ifData=0x2002000A; stall low in cycle 2 only.
- Simultaneous memRead (dAddr=0x100) and ifReq (ifAddr=0x44), 2 wait-states each → data served first, fetch issued back-to-back; dRData and ifData correct; stall low exactly once.
- Store dAddr=0x8, dWData=0xDEADBEEF → mWe=1 and mWData held stable across 3 wait cycles; dRData unchanged.
- No mAck for TIMEOUT+1 cycles during a fetch → busErr set and stays set; stall releases; FSM returns to IDLE; next request served normally.
- rst asserted mid-DATA with mReq high → mReq, mWe and outputs go to 0 asynchronously; a stray mAck the following cycle changes nothing.
- ifReq dropped before mAck of an in-flight fetch → transaction completes, ifData unchanged, fFlag stays 0.
